// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end.
// Owns the PC and issues in-order fetch requests to the I-cache. Returned
// instructions go into a DEPTH-entry in-order queue and are presented to
// decode. Redirects (load_pc) flush the queue. Responses still owed for
// flushed requests are counted in drop_cnt and discarded when they arrive.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   hc_stall, hc_flush             IF stall (blocks requests) / IF bubble
//   load_pc_we, load_pc_new_pc     redirect strobe and target
//   ic_req_valid/addr/ready        fetch request handshake
//   ic_rsp_valid/data              in-order instruction return
//   dec_valid/pc/instr, dec_ready  head instruction to decode
//   stat_redirects, stat_dropped   event counters
//
// Optional feature: define FETCH_QUEUE_STATS_EN to enable the saturating
// stat counters. When it is undefined, both stat outputs are tied to 0.
module fetch_queue_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hc_stall,
  input  logic                  hc_flush,
  input  logic                  load_pc_we,
  input  logic [ADDR_WIDTH-1:0] load_pc_new_pc,
  output logic                  ic_req_valid,
  output logic [ADDR_WIDTH-1:0] ic_req_addr,
  input  logic                  ic_req_ready,
  input  logic                  ic_rsp_valid,
  input  logic [ADDR_WIDTH-1:0] ic_rsp_data,
  output logic                  dec_valid,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [ADDR_WIDTH-1:0] dec_instr,
  input  logic                  dec_ready,
  output logic [31:0]           stat_redirects,
  output logic [31:0]           stat_dropped
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 16;

  logic [DEPTH-1:0]      ent_alloc;
  logic [DEPTH-1:0]      ent_filled;
  logic [ADDR_WIDTH-1:0] ent_pc    [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_instr [DEPTH];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      fill_ptr;   // oldest allocated-but-unfilled entry
  logic [CNT_W-1:0]      alloc_cnt;
  logic [CNT_W-1:0]      pend_cnt;   // allocated entries still awaiting data
  logic [DROP_W-1:0]     drop_cnt;   // responses owed for flushed requests
  logic [ADDR_WIDTH-1:0] pc;

  logic req_fire;
  logic drop_now;
  logic fill_now;
  logic pop;

  // Handshake and event decode. The full check uses the registered count,
  // so a pop never frees a slot for an allocation in the same cycle.
  always_comb begin
    ic_req_valid = ~rst & ~hc_stall & ~load_pc_we & (alloc_cnt < CNT_W'(DEPTH));
    ic_req_addr  = pc;
    dec_valid    = ~rst & ~load_pc_we & ~hc_flush & ent_alloc[head] & ent_filled[head];
    dec_pc       = ent_pc[head];
    dec_instr    = ent_instr[head];
    req_fire     = ic_req_valid & ic_req_ready;
    drop_now     = ic_rsp_valid & (drop_cnt != '0);
    fill_now     = ic_rsp_valid & (drop_cnt == '0) & (pend_cnt != '0);
    pop          = dec_valid & dec_ready;
  end

  // Control state: pointers, counts, valid bits, PC and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      alloc_cnt  <= '0;
      pend_cnt   <= '0;
      drop_cnt   <= '0;
      ent_alloc  <= '0;
      ent_filled <= '0;
    end else if (load_pc_we) begin
      // Unfilled entries become owed responses. A response arriving now
      // either fills (one fewer owed) or is itself dropped.
      pc         <= load_pc_new_pc;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      alloc_cnt  <= '0;
      pend_cnt   <= '0;
      ent_alloc  <= '0;
      ent_filled <= '0;
      drop_cnt   <= drop_cnt + DROP_W'(pend_cnt) - DROP_W'(drop_now) - DROP_W'(fill_now);
    end else begin
      if (req_fire) begin
        ent_alloc[tail]  <= 1'b1;
        ent_filled[tail] <= 1'b0;
        tail             <= tail + PTR_W'(1);
        pc               <= pc + ADDR_WIDTH'(4);
      end
      if (fill_now) begin
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + PTR_W'(1);
      end
      if (drop_now) begin
        drop_cnt <= drop_cnt - DROP_W'(1);
      end
      if (pop) begin
        ent_alloc[head]  <= 1'b0;
        ent_filled[head] <= 1'b0;
        head             <= head + PTR_W'(1);
      end
      alloc_cnt <= alloc_cnt + CNT_W'(req_fire) - CNT_W'(pop);
      pend_cnt  <= pend_cnt + CNT_W'(req_fire) - CNT_W'(fill_now);
    end
  end

  // Entry payload storage; needs no reset because the valid bits guard it.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      ent_pc[tail] <= pc;
    end
    if (fill_now && !rst && !load_pc_we) begin
      ent_instr[fill_ptr] <= ic_rsp_data;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] redir_q;
  logic [31:0] drop_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_q <= '0;
      drop_q  <= '0;
    end else begin
      if (load_pc_we && (redir_q != 32'hFFFF_FFFF)) begin
        redir_q <= redir_q + 32'd1;
      end
      if (drop_now && (drop_q != 32'hFFFF_FFFF)) begin
        drop_q <= drop_q + 32'd1;
      end
    end
  end

  assign stat_redirects = redir_q;
  assign stat_dropped   = drop_q;

`ifdef SIMULATION
  // Hook for simulation-side statistics collection.
  function automatic void stats_event(input string name);
    string tag;
    tag = name;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_pc_we) stats_event("fq_redirect");
      if (drop_now)   stats_event("fq_drop");
    end
  end
`endif
`else
  assign stat_redirects = '0;
  assign stat_dropped   = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: directed scenarios followed by random
// traffic, all checked each cycle against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_QUEUE_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, hc_stall, hc_flush, load_pc_we;
  logic [AW-1:0] load_pc_new_pc;
  logic          ic_req_valid, ic_req_ready, ic_rsp_valid;
  logic [AW-1:0] ic_req_addr, ic_rsp_data;
  logic          dec_valid, dec_ready;
  logic [AW-1:0] dec_pc, dec_instr;
  logic [31:0]   stat_redirects, stat_dropped;

  always #5 clk = ~clk;

  fetch_queue_unit #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .hc_stall(hc_stall), .hc_flush(hc_flush),
    .load_pc_we(load_pc_we), .load_pc_new_pc(load_pc_new_pc),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_ready(dec_ready),
    .stat_redirects(stat_redirects), .stat_dropped(stat_dropped)
  );

  // Reference model: in-order list of live fetches plus owed-response count.
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int due; } req_t;
  ent_t        mq[$];
  req_t        cq[$];          // I-cache emulator: accepted, not yet returned
  logic [31:0] m_pc;
  int          m_drop;
  logic [31:0] m_sr, m_sd;

  // Logs of DUT-observed handshakes, used by the directed checks.
  logic [31:0] req_addr_log[$], req_cyc_log[$], pop_pc_log[$], pop_instr_log[$], pop_cyc_log[$];
  // Snapshot of DUT outputs from the most recent cycle.
  logic        o_rv, o_dv;
  logic [31:0] o_addr, o_pc, o_sd;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int lat_lo = 1, lat_hi = 1, rsp_pct = 100, spur_pct = 0;
  bit rdy_rand = 1'b0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    req_addr_log.delete(); req_cyc_log.delete();
    pop_pc_log.delete(); pop_instr_log.delete(); pop_cyc_log.delete();
  endtask

  // One clock: drive the cache side, compare against the model, advance it.
  task automatic cycle();
    bit exp_rv, exp_dv, fire, popping, dropped, filling, done;
    int unf;
    ic_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    ic_rsp_valid = 1'b0;
    ic_rsp_data  = '0;
    if (cq.size() > 0) begin
      if (cq[0].due <= cyc && $urandom_range(0, 99) < rsp_pct) begin
        ic_rsp_valid = 1'b1;
        ic_rsp_data  = imem(cq[0].addr);
        void'(cq.pop_front());
      end
    end else if ($urandom_range(0, 99) < spur_pct) begin
      ic_rsp_valid = 1'b1;
      ic_rsp_data  = $urandom;
    end
    #1;
    o_rv = ic_req_valid; o_dv = dec_valid; o_addr = ic_req_addr;
    o_pc = dec_pc; o_sd = stat_dropped;

    exp_rv = !rst && !hc_stall && !load_pc_we && (mq.size() < DEPTH);
    exp_dv = !rst && !load_pc_we && !hc_flush && (mq.size() > 0) && mq[0].filled;
    chk("ic_req_valid", 32'(ic_req_valid), 32'(exp_rv));
    if (exp_rv) chk("ic_req_addr", ic_req_addr, m_pc);
    chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
    if (exp_dv) begin
      chk("dec_pc", dec_pc, mq[0].pc);
      chk("dec_instr", dec_instr, mq[0].instr);
    end
    if (!rst) begin
      chk("stat_redirects", stat_redirects, STATS_ON ? m_sr : 32'h0);
      chk("stat_dropped", stat_dropped, STATS_ON ? m_sd : 32'h0);
    end

    if (ic_req_valid && ic_req_ready) begin
      req_addr_log.push_back(ic_req_addr); req_cyc_log.push_back(32'(cyc));
    end
    if (dec_valid && dec_ready) begin
      pop_pc_log.push_back(dec_pc); pop_instr_log.push_back(dec_instr);
      pop_cyc_log.push_back(32'(cyc));
    end

    fire = exp_rv && ic_req_ready;
    if (rst) begin
      m_pc = RPC; mq.delete(); cq.delete(); m_drop = 0; m_sr = '0; m_sd = '0;
    end else begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      dropped = ic_rsp_valid && (m_drop > 0);
      filling = ic_rsp_valid && (m_drop == 0) && (unf > 0);
      if (dropped && m_sd != 32'hFFFF_FFFF) m_sd++;
      if (load_pc_we) begin
        if (m_sr != 32'hFFFF_FFFF) m_sr++;
        m_drop = m_drop - int'(dropped) + unf - int'(filling);
        mq.delete();
        m_pc = load_pc_new_pc;
      end else begin
        popping = exp_dv && dec_ready;
        if (dropped) m_drop--;
        done = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
          if (filling && !done && !mq[i].filled) begin
            mq[i].filled = 1'b1; mq[i].instr = ic_rsp_data; done = 1'b1;
          end
        end
        if (popping) void'(mq.pop_front());
        if (fire) begin
          mq.push_back('{pc: m_pc, instr: 32'h0, filled: 1'b0});
          cq.push_back('{addr: m_pc, due: cyc + int'($urandom_range(lat_lo, lat_hi))});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    hc_stall = 1'b0; hc_flush = 1'b0; load_pc_we = 1'b0;
    load_pc_new_pc = '0; dec_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_req_valid", 32'(o_rv), 32'h0);
    chk("rst_dec_valid", 32'(o_dv), 32'h0);
    chk("rst_req_addr", o_addr, RPC);
    chk("rst_stat_dropped", o_sd, 32'h0);
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst = 1'b1; idle_inputs();
    ic_req_ready = 1'b0; ic_rsp_valid = 1'b0; ic_rsp_data = '0;
    m_pc = RPC; m_drop = 0; m_sr = '0; m_sd = '0;
    @(posedge clk); #1;

    // Streaming with 1-cycle latency: 0,4,8 issued and decoded back-to-back.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (6) cycle();
    chk("t1_req0", at(req_addr_log, 0), 32'h0);
    chk("t1_req1", at(req_addr_log, 1), 32'h4);
    chk("t1_req2", at(req_addr_log, 2), 32'h8);
    chk("t1_pop0", at(pop_pc_log, 0), 32'h0);
    chk("t1_pop1", at(pop_pc_log, 1), 32'h4);
    chk("t1_pop2", at(pop_pc_log, 2), 32'h8);
    chk("t1_instr1", at(pop_instr_log, 1), imem(32'h4));
    chk("t1_fill_lat", at(pop_cyc_log, 0) - at(req_cyc_log, 0), 32'd2);
    chk("t1_pop_gap", at(pop_cyc_log, 2) - at(pop_cyc_log, 1), 32'd1);

    // Full queue: exactly DEPTH accepted, a pop frees a slot one cycle later.
    do_reset();
    dec_ready = 1'b0;
    repeat (8) cycle();
    chk("t2_nreq", 32'(req_addr_log.size()), 32'(DEPTH));
    chk("t2_blocked", 32'(o_rv), 32'h0);
    dec_ready = 1'b1;
    cycle();
    chk("t2_pop0", at(pop_pc_log, 0), 32'h0);
    chk("t2_no_same_cycle_req", 32'(o_rv), 32'h0);
    cycle();
    chk("t2_req_after_pop", at(req_addr_log, 4), 32'h10);
    chk("t2_req_delay", at(req_cyc_log, 4) - at(pop_cyc_log, 0), 32'd1);

    // Redirect with 3 in flight: all 3 late responses are discarded.
    do_reset();
    lat_lo = 5; lat_hi = 5;
    repeat (3) cycle();
    lat_lo = 1; lat_hi = 1;
    load_pc_we = 1'b1; load_pc_new_pc = 32'h100;
    cycle();
    load_pc_we = 1'b0;
    repeat (10) cycle();
    chk("t3_first_pop", at(pop_pc_log, 0), 32'h100);
    chk("t3_first_instr", at(pop_instr_log, 0), imem(32'h100));
    chk("t3_stat_dropped", o_sd, STATS_ON ? 32'd3 : 32'd0);

    // Redirect coinciding with a response, 2 outstanding: only one dropped.
    do_reset();
    lat_lo = 2; lat_hi = 2;
    repeat (2) cycle();
    load_pc_we = 1'b1; load_pc_new_pc = 32'h100;
    cycle();
    load_pc_we = 1'b0;
    repeat (8) cycle();
    chk("t4_first_pop", at(pop_pc_log, 0), 32'h100);
    chk("t4_first_instr", at(pop_instr_log, 0), imem(32'h100));
    chk("t4_stat_dropped", o_sd, STATS_ON ? 32'd1 : 32'd0);

    // Stall with 2 filled entries: no requests, pops continue, flush bubbles.
    do_reset();
    lat_lo = 1; lat_hi = 1; dec_ready = 1'b0;
    repeat (2) cycle();
    hc_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dec_ready = (i >= 2);
      hc_flush  = (i == 2);
      cycle();
      chk("t5_stall_req", 32'(o_rv), 32'h0);
      if (i == 2) begin
        chk("t5_flush_bubble", 32'(o_dv), 32'h0);
        chk("t5_flush_head", o_pc, 32'h0);
      end
    end
    hc_stall = 1'b0; hc_flush = 1'b0; dec_ready = 1'b1;
    chk("t5_pop0", at(pop_pc_log, 0), 32'h0);
    chk("t5_pop1", at(pop_pc_log, 1), 32'h4);
    chk("t5_npop", 32'(pop_pc_log.size()), 32'd2);

    // PC wrap at the top of the address space, then mid-stream reset.
    do_reset();
    load_pc_we = 1'b1; load_pc_new_pc = 32'hFFFF_FFFC;
    cycle();
    load_pc_we = 1'b0;
    repeat (3) cycle();
    chk("t6_top", at(req_addr_log, 0), 32'hFFFF_FFFC);
    chk("t6_wrap", at(req_addr_log, 1), 32'h0000_0000);
    do_reset();

    // Random traffic against the model.
    rdy_rand = 1'b1; lat_lo = 1; lat_hi = 4; rsp_pct = 70; spur_pct = 3;
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 999) < 4);
      hc_stall       = ($urandom_range(0, 99) < 20);
      hc_flush       = ($urandom_range(0, 99) < 10);
      load_pc_we     = ($urandom_range(0, 99) < 5);
      load_pc_new_pc = $urandom & 32'hFFFF_FFFC;
      dec_ready      = ($urandom_range(0, 99) < 70);
      cycle();
    end
    rst = 1'b0; idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
